// File: rtl/ifetch_line_buffer.sv
// Single-line instruction fetch buffer: holds one 64-byte ROM line and serves aligned
// 32-bit reads from it, refilling the whole line from the ROM on a miss.
module ifetch_line_buffer #(
  parameter int ADDR_W  = 15,
  parameter int LINE_W  = 512,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              cpu_req,
  input  logic [31:0]       cpu_addr,
  output logic              cpu_ready,
  output logic [31:0]       cpu_instr,
  output logic              cpu_err,
  output logic              mem_cs,
  output logic              mem_addr_valid,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_data_ready,
  input  logic [LINE_W-1:0] mem_data
);

  localparam int IDX_W = ADDR_W - 6;
  localparam int WORDS = LINE_W / 32;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, FILL, RESP} state_t;

  state_t                      state_q, state_d;
  logic                        line_valid_q, line_valid_d;
  logic [IDX_W-1:0]            tag_q, tag_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [WORDS-1:0][31:0]      line_q;
  logic                        cap;
  logic                        ready_d, err_d, cs_d, av_d;
  logic [31:0]                 instr_d;
  logic [ADDR_W-1:0]           maddr_d;
  logic                        hit, bad, rom_rdy;

  // A same-cycle flush invalidates the line before the request is judged.
  assign hit     = line_valid_q && !flush && (tag_q == cpu_addr[ADDR_W-1:6]);
  assign bad     = (|cpu_addr[1:0]) || (|cpu_addr[31:ADDR_W]);
  assign rom_rdy = (mem_data_ready === 1'b1);

  always_comb begin
    state_d      = state_q;
    line_valid_d = line_valid_q;
    tag_d        = tag_q;
    cnt_d        = cnt_q;
    cap          = 1'b0;
    ready_d      = 1'b0;
    err_d        = 1'b0;
    instr_d      = '0;
    cs_d         = mem_cs;
    av_d         = mem_addr_valid;
    maddr_d      = mem_addr;
    case (state_q)
      IDLE: if (cpu_req) begin
        if (bad) begin
          state_d = RESP;
          ready_d = 1'b1;
          err_d   = 1'b1;
        end else if (hit) begin
          state_d = RESP;
          ready_d = 1'b1;
          instr_d = line_q[cpu_addr[5:2]];
        end else begin
          state_d = FILL;
          cs_d    = 1'b1;
          av_d    = 1'b1;
          maddr_d = {cpu_addr[ADDR_W-1:6], 6'b0};
          cnt_d   = '0;
        end
      end
      FILL: begin
        if (flush) begin
          state_d = IDLE;
          cs_d    = 1'b0;
          av_d    = 1'b0;
        end else if (rom_rdy) begin
          // Tag from the latched ROM address: cpu_addr may move if cpu_req dropped.
          cap          = 1'b1;
          tag_d        = mem_addr[ADDR_W-1:6];
          line_valid_d = 1'b1;
          cs_d         = 1'b0;
          av_d         = 1'b0;
          state_d      = IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          cs_d         = 1'b0;
          av_d         = 1'b0;
          line_valid_d = 1'b0;
          state_d      = RESP;
          ready_d      = 1'b1;
          err_d        = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) line_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      line_valid_q   <= 1'b0;
      tag_q          <= '0;
      cnt_q          <= '0;
      cpu_ready      <= 1'b0;
      cpu_err        <= 1'b0;
      cpu_instr      <= '0;
      mem_cs         <= 1'b0;
      mem_addr_valid <= 1'b0;
      mem_addr       <= '0;
    end else begin
      state_q        <= state_d;
      line_valid_q   <= line_valid_d;
      tag_q          <= tag_d;
      cnt_q          <= cnt_d;
      cpu_ready      <= ready_d;
      cpu_err        <= err_d;
      cpu_instr      <= instr_d;
      mem_cs         <= cs_d;
      mem_addr_valid <= av_d;
      mem_addr       <= maddr_d;
    end
  end

  // Line data needs no reset; line_valid guards it.
  always_ff @(posedge clk) begin
    if (cap) line_q <= mem_data;
  end

endmodule
